// File: rtl/mc_main_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller: FSM states, opcode/funct
// constants, ALU-op encodings and datapath select codes.
package mc_main_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecR,
        StWbR,
        StExecI,
        StWbI,
        StMemAddr,
        StMemRd,
        StWbMem,
        StMemWr,
        StBranch,
        StJump,
        StTrap
    } state_e;

    // Which ALU function family the current state asks the decoder for.
    typedef enum logic [1:0] {
        AluClsAdd,
        AluClsSub,
        AluClsR,
        AluClsI
    } alu_cls_e;

    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_ADDU = 4'd1;
    localparam logic [3:0] ALUOP_SUB  = 4'd2;
    localparam logic [3:0] ALUOP_SUBU = 4'd3;
    localparam logic [3:0] ALUOP_AND  = 4'd4;
    localparam logic [3:0] ALUOP_OR   = 4'd5;
    localparam logic [3:0] ALUOP_XOR  = 4'd6;
    localparam logic [3:0] ALUOP_NOR  = 4'd7;
    localparam logic [3:0] ALUOP_SLT  = 4'd8;
    localparam logic [3:0] ALUOP_SLTU = 4'd9;
    localparam logic [3:0] ALUOP_SLLV = 4'd10;
    localparam logic [3:0] ALUOP_SRLV = 4'd11;
    localparam logic [3:0] ALUOP_SRAV = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_BR   = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    function automatic logic funct_legal(input logic [5:0] fn);
        logic ok;
        unique case (fn)
            FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: ok = 1'b1;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_main_ctrl_alu_decode.sv
// Combinational ALU-op decoder: maps the ALU class requested by the FSM plus the latched
// opcode/funct onto an ALU operation and the immediate-extension mode.
module mc_alu_decode
    import mc_main_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  alu_cls_e   alu_cls_i,
    output logic [3:0] alu_op_o,
    output logic       ext_zero_o
);

    always_comb begin
        alu_op_o   = ALUOP_ADD;
        ext_zero_o = 1'b0;
        unique case (alu_cls_i)
            AluClsAdd: alu_op_o = ALUOP_ADD;
            AluClsSub: alu_op_o = ALUOP_SUB;
            AluClsR: begin
                case (funct_i)
                    FN_ADD:  alu_op_o = ALUOP_ADD;
                    FN_ADDU: alu_op_o = ALUOP_ADDU;
                    FN_SUB:  alu_op_o = ALUOP_SUB;
                    FN_SUBU: alu_op_o = ALUOP_SUBU;
                    FN_AND:  alu_op_o = ALUOP_AND;
                    FN_OR:   alu_op_o = ALUOP_OR;
                    FN_XOR:  alu_op_o = ALUOP_XOR;
                    FN_NOR:  alu_op_o = ALUOP_NOR;
                    FN_SLT:  alu_op_o = ALUOP_SLT;
                    FN_SLTU: alu_op_o = ALUOP_SLTU;
                    FN_SLLV: alu_op_o = ALUOP_SLLV;
                    FN_SRLV: alu_op_o = ALUOP_SRLV;
                    FN_SRAV: alu_op_o = ALUOP_SRAV;
                    default: alu_op_o = ALUOP_ADD;
                endcase
            end
            AluClsI: begin
                // Logical immediates zero-extend; arithmetic and compares sign-extend.
                case (opcode_i)
                    OP_ADDI:  alu_op_o = ALUOP_ADD;
                    OP_ADDIU: alu_op_o = ALUOP_ADDU;
                    OP_SLTI:  alu_op_o = ALUOP_SLT;
                    OP_SLTIU: alu_op_o = ALUOP_SLTU;
                    OP_ANDI: begin
                        alu_op_o   = ALUOP_AND;
                        ext_zero_o = 1'b1;
                    end
                    OP_ORI: begin
                        alu_op_o   = ALUOP_OR;
                        ext_zero_o = 1'b1;
                    end
                    OP_XORI: begin
                        alu_op_o   = ALUOP_XOR;
                        ext_zero_o = 1'b1;
                    end
                    default: alu_op_o = ALUOP_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute/memory/
// writeback and drives every datapath select and write strobe.
module mc_main_ctrl
    import mc_main_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_source,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ext_zero,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               instr_done,
    output logic               illegal
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] funct_q, funct_d;
    logic       illegal_q, illegal_d;
    alu_cls_e   alu_cls;
    logic [3:0] alu_op_dec;
    logic       ext_zero_dec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            funct_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        funct_d   = funct_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: if (mem_ready) state_d = StDecode;
            StDecode: begin
                op_d    = opcode;
                funct_d = funct;
                case (opcode)
                    OP_RTYPE:       state_d = funct_legal(funct) ? StExecR : StTrap;
                    OP_LW, OP_SW:   state_d = StMemAddr;
                    OP_BEQ, OP_BNE: state_d = StBranch;
                    OP_J:           state_d = StJump;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU:
                        state_d = StExecI;
                    default:        state_d = StTrap;
                endcase
            end
            StExecR:   state_d = StWbR;
            StWbR:     state_d = StFetch;
            StExecI:   state_d = StWbI;
            StWbI:     state_d = StFetch;
            StMemAddr: state_d = (op_q == OP_LW) ? StMemRd : StMemWr;
            StMemRd:   if (mem_ready) state_d = StWbMem;
            StWbMem:   state_d = StFetch;
            StMemWr:   if (mem_ready) state_d = StFetch;
            StBranch:  state_d = StFetch;
            StJump:    state_d = StFetch;
            StTrap:    state_d = StTrap;
            default:   state_d = StIdle;
        endcase
        // Raised on entry so illegal is already high in the first TRAP cycle.
        if (state_d == StTrap) illegal_d = 1'b1;
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = PCSRC_ALU;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        instr_done = 1'b0;
        alu_cls    = AluClsAdd;
        unique case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: alu_src_b = SRCB_BR;
            StExecR: begin
                alu_src_a = 1'b1;
                alu_cls   = AluClsR;
            end
            StWbR: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_cls   = AluClsI;
            end
            StWbI: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_cls    = AluClsSub;
                pc_source  = PCSRC_ALUOUT;
                pc_write   = ((op_q == OP_BEQ) & zero) | ((op_q == OP_BNE) & ~zero);
                instr_done = 1'b1;
            end
            StJump: begin
                pc_source  = PCSRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    mc_alu_decode u_alu_decode (
        .opcode_i   (op_q),
        .funct_i    (funct_q),
        .alu_cls_i  (alu_cls),
        .alu_op_o   (alu_op_dec),
        .ext_zero_o (ext_zero_dec)
    );

    // The decoder only asserts ext_zero for the I-type class, which only EXEC_I selects.
    assign ext_zero = ext_zero_dec;
    assign alu_op   = ALUOP_W'(alu_op_dec);
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Table-driven bench for mc_main_ctrl: per-cycle input/expected-output vectors fed through
// a scoreboard queue and compared away from the clock edge.
module tb_mc_main_ctrl;
    import mc_main_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0] pc_source;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [3:0] alu_op;
    logic       instr_done, illegal;

    always #5 clk = ~clk;

    mc_main_ctrl #(.ALUOP_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_zero   (ext_zero),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [3:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } exp_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        exp_t       e;
    } vec_t;

    vec_t  vecs[$];
    string tags[$];
    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic exp_t e_zero();
        exp_t e = '0;
        return e;
    endfunction

    function automatic exp_t e_fetch(input logic rdy);
        exp_t e = '0;
        e.mem_read  = 1'b1;
        e.alu_src_b = 2'd1;
        e.ir_write  = rdy;
        e.pc_write  = rdy;
        return e;
    endfunction

    function automatic exp_t e_decode();
        exp_t e = '0;
        e.alu_src_b = 2'd3;
        return e;
    endfunction

    function automatic exp_t e_exec_r(input logic [3:0] op);
        exp_t e = '0;
        e.alu_src_a = 1'b1;
        e.alu_op    = op;
        return e;
    endfunction

    function automatic exp_t e_exec_i(input logic [3:0] op, input logic ez);
        exp_t e = '0;
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'd2;
        e.alu_op    = op;
        e.ext_zero  = ez;
        return e;
    endfunction

    function automatic exp_t e_wb(input logic dst, input logic m2r);
        exp_t e = '0;
        e.reg_write  = 1'b1;
        e.reg_dst    = dst;
        e.mem_to_reg = m2r;
        e.instr_done = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_mem(input logic wr, input logic rdy);
        exp_t e = '0;
        e.i_or_d     = 1'b1;
        e.mem_read   = ~wr;
        e.mem_write  = wr;
        e.instr_done = wr & rdy;
        return e;
    endfunction

    function automatic exp_t e_branch(input logic taken);
        exp_t e = '0;
        e.alu_src_a  = 1'b1;
        e.alu_op     = ALUOP_SUB;
        e.pc_source  = 2'd1;
        e.pc_write   = taken;
        e.instr_done = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_jump();
        exp_t e = '0;
        e.pc_source  = 2'd2;
        e.pc_write   = 1'b1;
        e.instr_done = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_trap();
        exp_t e = '0;
        e.illegal = 1'b1;
        return e;
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input exp_t e, input string nm);
        vec_t v;
        v.rst_n = r;
        v.op    = op;
        v.fn    = fn;
        v.z     = z;
        v.rdy   = rdy;
        v.e     = e;
        vecs.push_back(v);
        tags.push_back(nm);
    endtask

    task automatic check(input string nm);
        exp_t want, got;
        want = exp_q.pop_front();
        got  = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_op, instr_done, illegal};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %05h required %05h", nm, got, want);
        end
    endtask

    initial begin
        // addu, zero-wait memory: done in the 4th cycle counted from FETCH.
        add(1, 6'h00, 6'h21, 0, 1, e_zero(),            "idle after reset");
        add(1, 6'h00, 6'h21, 0, 1, e_fetch(1),          "addu fetch");
        add(1, 6'h00, 6'h21, 0, 1, e_decode(),          "addu decode");
        add(1, 6'h00, 6'h21, 0, 1, e_exec_r(ALUOP_ADDU), "addu exec");
        add(1, 6'h00, 6'h21, 0, 1, e_wb(1, 0),          "addu wb");
        // sub / srav / nor R-types; mem_ready low in DECODE must be ignored.
        add(1, 6'h00, 6'h22, 0, 1, e_fetch(1),          "sub fetch");
        add(1, 6'h00, 6'h22, 0, 0, e_decode(),          "sub decode");
        add(1, 6'h00, 6'h22, 0, 0, e_exec_r(ALUOP_SUB), "sub exec");
        add(1, 6'h00, 6'h22, 0, 0, e_wb(1, 0),          "sub wb");
        add(1, 6'h00, 6'h07, 0, 1, e_fetch(1),          "srav fetch");
        add(1, 6'h00, 6'h07, 0, 1, e_decode(),          "srav decode");
        add(1, 6'h00, 6'h07, 0, 1, e_exec_r(ALUOP_SRAV), "srav exec");
        add(1, 6'h00, 6'h07, 0, 1, e_wb(1, 0),          "srav wb");
        add(1, 6'h00, 6'h27, 0, 1, e_fetch(1),          "nor fetch");
        add(1, 6'h00, 6'h27, 0, 1, e_decode(),          "nor decode");
        add(1, 6'h00, 6'h27, 0, 1, e_exec_r(ALUOP_NOR), "nor exec");
        add(1, 6'h00, 6'h27, 0, 1, e_wb(1, 0),          "nor wb");
        // lw with two wait cycles in MEM_RD: 7 cycles total.
        add(1, 6'h23, 6'h00, 0, 1, e_fetch(1),          "lw fetch");
        add(1, 6'h23, 6'h00, 0, 1, e_decode(),          "lw decode");
        add(1, 6'h23, 6'h00, 0, 1, e_exec_i(ALUOP_ADD, 0), "lw addr");
        add(1, 6'h23, 6'h00, 0, 0, e_mem(0, 0),         "lw rd wait1");
        add(1, 6'h23, 6'h00, 0, 0, e_mem(0, 0),         "lw rd wait2");
        add(1, 6'h23, 6'h00, 0, 1, e_mem(0, 1),         "lw rd ready");
        add(1, 6'h23, 6'h00, 0, 1, e_wb(0, 1),          "lw wb");
        // beq taken with a FETCH stall, beq not taken, bne both ways.
        add(1, 6'h04, 6'h00, 1, 0, e_fetch(0),          "beq fetch stall");
        add(1, 6'h04, 6'h00, 1, 1, e_fetch(1),          "beq fetch");
        add(1, 6'h04, 6'h00, 1, 1, e_decode(),          "beq decode");
        add(1, 6'h04, 6'h00, 1, 1, e_branch(1),         "beq z1 taken");
        add(1, 6'h04, 6'h00, 0, 1, e_fetch(1),          "beq0 fetch");
        add(1, 6'h04, 6'h00, 0, 1, e_decode(),          "beq0 decode");
        add(1, 6'h04, 6'h00, 0, 1, e_branch(0),         "beq z0 not taken");
        add(1, 6'h05, 6'h00, 0, 1, e_fetch(1),          "bne fetch");
        add(1, 6'h05, 6'h00, 0, 1, e_decode(),          "bne decode");
        add(1, 6'h05, 6'h00, 0, 1, e_branch(1),         "bne z0 taken");
        add(1, 6'h05, 6'h00, 1, 1, e_fetch(1),          "bne1 fetch");
        add(1, 6'h05, 6'h00, 1, 1, e_decode(),          "bne1 decode");
        add(1, 6'h05, 6'h00, 1, 1, e_branch(0),         "bne z1 not taken");
        // I-types: logical zero-extend, arithmetic/compare sign-extend.
        add(1, 6'h0D, 6'h25, 0, 1, e_fetch(1),          "ori fetch");
        add(1, 6'h0D, 6'h25, 0, 1, e_decode(),          "ori decode");
        add(1, 6'h0D, 6'h25, 0, 1, e_exec_i(ALUOP_OR, 1), "ori exec");
        add(1, 6'h0D, 6'h25, 0, 1, e_wb(0, 0),          "ori wb");
        add(1, 6'h08, 6'h00, 0, 1, e_fetch(1),          "addi fetch");
        add(1, 6'h08, 6'h00, 0, 1, e_decode(),          "addi decode");
        add(1, 6'h08, 6'h00, 0, 1, e_exec_i(ALUOP_ADD, 0), "addi exec");
        add(1, 6'h08, 6'h00, 0, 1, e_wb(0, 0),          "addi wb");
        add(1, 6'h0B, 6'h00, 0, 1, e_fetch(1),          "sltiu fetch");
        add(1, 6'h0B, 6'h00, 0, 1, e_decode(),          "sltiu decode");
        add(1, 6'h0B, 6'h00, 0, 1, e_exec_i(ALUOP_SLTU, 0), "sltiu exec");
        add(1, 6'h0B, 6'h00, 0, 1, e_wb(0, 0),          "sltiu wb");
        add(1, 6'h0E, 6'h00, 0, 1, e_fetch(1),          "xori fetch");
        add(1, 6'h0E, 6'h00, 0, 1, e_decode(),          "xori decode");
        add(1, 6'h0E, 6'h00, 0, 1, e_exec_i(ALUOP_XOR, 1), "xori exec");
        add(1, 6'h0E, 6'h00, 0, 1, e_wb(0, 0),          "xori wb");
        // j
        add(1, 6'h02, 6'h00, 0, 1, e_fetch(1),          "j fetch");
        add(1, 6'h02, 6'h00, 0, 1, e_decode(),          "j decode");
        add(1, 6'h02, 6'h00, 0, 1, e_jump(),            "j jump");
        // sw with one wait cycle; instr_done only with mem_ready.
        add(1, 6'h2B, 6'h00, 0, 1, e_fetch(1),          "sw fetch");
        add(1, 6'h2B, 6'h00, 0, 1, e_decode(),          "sw decode");
        add(1, 6'h2B, 6'h00, 0, 1, e_exec_i(ALUOP_ADD, 0), "sw addr");
        add(1, 6'h2B, 6'h00, 0, 0, e_mem(1, 0),         "sw wr wait");
        add(1, 6'h2B, 6'h00, 0, 1, e_mem(1, 1),         "sw wr ready");
        // sw interrupted by reset during the MEM_WR stall.
        add(1, 6'h2B, 6'h00, 0, 1, e_fetch(1),          "sw2 fetch");
        add(1, 6'h2B, 6'h00, 0, 1, e_decode(),          "sw2 decode");
        add(1, 6'h2B, 6'h00, 0, 1, e_exec_i(ALUOP_ADD, 0), "sw2 addr");
        add(0, 6'h2B, 6'h00, 0, 0, e_mem(1, 0),         "sw2 wr wait rst");
        add(1, 6'h2B, 6'h00, 0, 1, e_zero(),            "idle after mid-instr rst");
        // Unknown opcode traps; illegal stays set until reset.
        add(1, 6'h3F, 6'h00, 0, 1, e_fetch(1),          "bad op fetch");
        add(1, 6'h3F, 6'h00, 0, 1, e_decode(),          "bad op decode");
        for (int i = 0; i < 10; i++) begin
            add(1, 6'h3F, 6'h00, logic'(i[0]), 1, e_trap(), "bad op trap hold");
        end
        add(0, 6'h3F, 6'h00, 0, 1, e_trap(),            "trap at rst");
        add(1, 6'h00, 6'h01, 0, 1, e_zero(),            "idle illegal cleared");
        // R-type with unsupported funct.
        add(1, 6'h00, 6'h01, 0, 1, e_fetch(1),          "bad fn fetch");
        add(1, 6'h00, 6'h01, 0, 1, e_decode(),          "bad fn decode");
        add(1, 6'h00, 6'h01, 0, 1, e_trap(),            "bad fn trap");
        add(1, 6'h00, 6'h01, 1, 0, e_trap(),            "bad fn trap hold");
        add(0, 6'h00, 6'h01, 0, 1, e_trap(),            "bad fn trap at rst");
        add(1, 6'h00, 6'h21, 0, 1, e_zero(),            "idle after trap rst");
        add(1, 6'h00, 6'h21, 0, 1, e_fetch(1),          "fetch after trap rst");

        rst_n     = 1'b0;
        opcode    = '0;
        funct     = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            #1;
            rst_n     = vecs[i].rst_n;
            opcode    = vecs[i].op;
            funct     = vecs[i].fn;
            zero      = vecs[i].z;
            mem_ready = vecs[i].rdy;
            exp_q.push_back(vecs[i].e);
            @(negedge clk);
            check(tags[i]);
            @(posedge clk);
        end

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: %0d left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
Main control FSM for the multicycle MIPS core. It sequences the shared datapath ALU, register file, IR, PC and unified memory through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps, and it produces the ALU operation code for each step. It sits beside the datapath, takes opcode/funct/zero from it and returns all mux selects and write strobes. Memory access uses a ready handshake, so FETCH, MEM_RD and MEM_WR stall until memory completes.

Parameters:
ALUOP_W, 4, width of ALU operation code; encodings (ALUOP_ADD, ALUOP_SUB, ...) come from the shared ALU-op define file.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU equality flag (srcA == srcB)
mem_ready  in  1  memory completes the current access this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
i_or_d  out  1  address select: 0 = PC, 1 = ALUOut
ir_write  out  1  load IR
pc_write  out  1  load PC
pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
reg_write  out  1  register file write enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  0 = reg B, 1 = const 4, 2 = ext imm, 3 = sext imm<<2
ext_zero  out  1  1 = zero-extend imm (andi/ori/xori), else sign-extend
alu_op  out  ALUOP_W  ALU operation
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  sticky: unsupported opcode/funct seen

Behaviour:
- The state register updates on the rising clk edge. When rst_n=0 at an edge, the next state is IDLE, the op/funct latches clear and illegal clears. A reset mid-instruction (any state) abandons the instruction with no further strobes.
- IDLE: all outputs 0 (alu_op = ALUOP_ADD encoding, all selects 0). Next state is FETCH. All outputs are therefore 0 in the cycle after reset.
- Outputs are Moore (decoded from state and latched op) except pc_write/ir_write/instr_done, which are qualified by mem_ready or zero as stated below. Any signal not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0.
  - If mem_ready: ir_write=1, pc_write=1, next state DECODE.
  - Otherwise the FSM holds with strobes low and mem_read held high.
- DECODE: latch opcode/funct internally. alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target precomputed into ALUOut).
  - Next state: R-type → EXEC_R; lw/sw → MEM_ADDR; beq/bne → BRANCH; j → JUMP; addi/addiu/andi/ori/xori/slti/sltiu → EXEC_I; anything else → TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op mapped from funct: 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, 0x04 SLLV, 0x06 SRLV, 0x07 SRAV. Other funct values route DECODE → TRAP. Next state WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, ext_zero per opcode, alu_op = ADD/ADDU/AND/OR/XOR/SLT/SLTU. Next state WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next state FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready; instr_done=mem_ready. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_source=1. pc_write = (beq & zero) | (bne & ~zero). instr_done=1. Next state FETCH.
- JUMP: pc_source=2, pc_write=1, instr_done=1. Next state FETCH.
- TRAP: illegal=1 (sticky), all strobes 0. Stays in TRAP until reset.
- Latency with zero-wait memory, counted from FETCH: R/I-type 4 cycles, lw 5, sw 4, branch 3, j 3. Each mem_ready=0 cycle adds one cycle.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.

Decomposition:
- Shared define package: state encodings (S_IDLE..S_TRAP), opcode/funct constants, ALU-op encodings (existing ALUOP_* macros), alu_src_b/pc_source select codes.
- One sub-module, mc_alu_decode: purely combinational (latched opcode, funct, state class) → alu_op, ext_zero. It is reused by EXEC_R/EXEC_I.

Test Plan:
- Reset, then addu (op 0, funct 0x21), mem_ready=1 → IDLE 1 cycle; FETCH pc_write=ir_write=1; EXEC_R alu_op=ADDU; WB_R reg_write=1, reg_dst=1, instr_done at cycle 4.
- lw (0x23) with mem_ready low 2 cycles in MEM_RD → mem_read/i_or_d held 3 cycles, then WB_MEM mem_to_reg=1; total 7 cycles.
- beq (0x04) zero=1 → pc_write=1, pc_source=1. Same with zero=0 → pc_write=0. bne (0x05) zero=0 → pc_write=1.
- ori (0x0D) → EXEC_I ext_zero=1, alu_op=OR, alu_src_b=2; WB_I reg_dst=0.
- Opcode 0x3F, then R-type funct 0x01 → TRAP, illegal=1 sticky, no strobes for 10 cycles; rst_n=0 clears it.
- rst_n=0 during MEM_WR stall → next cycle IDLE, mem_write=0, no instr_done; then FETCH.
